// File: rtl/tlb_pkg.sv
// Shared TLB definitions: op encodings, geometry and the op-controller state type.
package tlb_pkg;

  localparam int TLBNUM = 32;
  localparam int IDXW   = 5;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] TLBP  = 3'd1;
  localparam logic [2:0] TLBR  = 3'd2;
  localparam logic [2:0] TLBWI = 3'd3;
  localparam logic [2:0] TLBWR = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    REFETCH
  } ctrl_state_t;

  // Encodings outside the four real ops behave exactly like NONE.
  function automatic logic is_tlb_op(input logic [2:0] op);
    return (op == TLBP) || (op == TLBR) || (op == TLBWI) || (op == TLBWR);
  endfunction

  function automatic logic is_tlb_write(input logic [2:0] op);
    return (op == TLBWI) || (op == TLBWR);
  endfunction

endpackage

// File: rtl/tlb_random_cnt.sv
// CP0 Random counter: counts down from TLBNUM-1 to Wired, then wraps back to TLBNUM-1.
module tlb_random_cnt
  import tlb_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            freeze,
  input  logic [IDXW-1:0] wired,
  input  logic            wired_we,
  output logic [IDXW-1:0] random
);

  localparam logic [IDXW-1:0] RAND_MAX = IDXW'(TLBNUM - 1);

  logic [IDXW-1:0] r_random;

  // A Wired write restarts the range even while an op holds the counter frozen.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_random <= RAND_MAX;
    end else if (wired_we) begin
      r_random <= RAND_MAX;
    end else if (!freeze) begin
      r_random <= (r_random <= wired) ? RAND_MAX : r_random - IDXW'(1);
    end
  end

  assign random = r_random;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from MEM onto the TLB, stalling the pipeline
// and turning TLB results into CP0 write strobes or a refetch request.
module tlb_op_ctrl
  import tlb_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  output logic            req_ready,
  input  logic            ex_flush_i,
  output logic            stall_o,
  output logic            refetch_o,
  input  logic [31:0]     cp0_index_i,
  input  logic [IDXW-1:0] cp0_wired_i,
  input  logic            cp0_wired_we,
  output logic [2:0]      tlb_typeM,
  output logic [31:0]     tlb_index_o,
  output logic [31:0]     tlb_random_o,
  input  logic [31:0]     tlb_index_i,
  input  logic [31:0]     tlb_entryhi_i,
  input  logic [31:0]     tlb_pagemask_i,
  input  logic [31:0]     tlb_entrylo0_i,
  input  logic [31:0]     tlb_entrylo1_i,
  output logic            cp0_index_we,
  output logic            cp0_tlbr_we,
  output logic [31:0]     cp0_wdata_index,
  output logic [31:0]     cp0_wdata_hi,
  output logic [31:0]     cp0_wdata_pm,
  output logic [31:0]     cp0_wdata_lo0,
  output logic [31:0]     cp0_wdata_lo1
);

  ctrl_state_t     r_state;
  ctrl_state_t     w_next;
  logic [2:0]      r_op;
  logic [IDXW-1:0] r_index;
  logic [31:0]     r_wdata_index;
  logic [31:0]     r_wdata_hi;
  logic [31:0]     r_wdata_pm;
  logic [31:0]     r_wdata_lo0;
  logic [31:0]     r_wdata_lo1;
  logic [IDXW-1:0] w_random;
  logic            w_accept;
  logic            w_freeze;
  logic            w_unused;

  assign w_unused = ^cp0_index_i[31:IDXW];

  assign w_accept = resetn && (r_state == IDLE) && req_valid && is_tlb_op(req_op) && !ex_flush_i;
  // Random must not move between accept and the write commit so TLBWR uses the value seen at accept.
  assign w_freeze = w_accept || (r_state == ISSUE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   w_next = is_tlb_write(r_op) ? REFETCH : CAPTURE;
      CAPTURE: w_next = IDLE;
      REFETCH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_op          <= NONE;
      r_index       <= '0;
      r_wdata_index <= '0;
      r_wdata_hi    <= '0;
      r_wdata_pm    <= '0;
      r_wdata_lo0   <= '0;
      r_wdata_lo1   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= req_op;
        r_index <= cp0_index_i[IDXW-1:0];
      end
      if ((r_state == ISSUE) && (r_op == TLBP)) begin
        r_wdata_index <= tlb_index_i;
      end
      if ((r_state == ISSUE) && (r_op == TLBR)) begin
        r_wdata_hi  <= tlb_entryhi_i;
        r_wdata_pm  <= tlb_pagemask_i;
        r_wdata_lo0 <= tlb_entrylo0_i;
        r_wdata_lo1 <= tlb_entrylo1_i;
      end
    end
  end

  tlb_random_cnt u_random (
    .clk      (clk),
    .resetn   (resetn),
    .freeze   (w_freeze),
    .wired    (cp0_wired_i),
    .wired_we (cp0_wired_we),
    .random   (w_random)
  );

  assign req_ready       = w_accept;
  assign stall_o         = w_accept || (r_state != IDLE);
  assign refetch_o       = (r_state == REFETCH);
  assign tlb_typeM       = (r_state == ISSUE) ? r_op : NONE;
  assign tlb_index_o     = {{(32-IDXW){1'b0}}, r_index};
  assign tlb_random_o    = {{(32-IDXW){1'b0}}, w_random};
  assign cp0_index_we    = (r_state == CAPTURE) && (r_op == TLBP);
  assign cp0_tlbr_we     = (r_state == CAPTURE) && (r_op == TLBR);
  assign cp0_wdata_index = r_wdata_index;
  assign cp0_wdata_hi    = r_wdata_hi;
  assign cp0_wdata_pm    = r_wdata_pm;
  assign cp0_wdata_lo0   = r_wdata_lo0;
  assign cp0_wdata_lo1   = r_wdata_lo1;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: a small TLB array stands in for the real TLB, and a
// phase-level model predicts every output on each falling clock edge.
module tb_tlb_op_ctrl;
  import tlb_pkg::*;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic            req_valid = 1'b0;
  logic [2:0]      req_op = NONE;
  logic            req_ready;
  logic            ex_flush_i = 1'b0;
  logic            stall_o;
  logic            refetch_o;
  logic [31:0]     cp0_index_i = '0;
  logic [IDXW-1:0] cp0_wired_i = '0;
  logic            cp0_wired_we = 1'b0;
  logic [2:0]      tlb_typeM;
  logic [31:0]     tlb_index_o;
  logic [31:0]     tlb_random_o;
  logic [31:0]     tlb_index_i;
  logic [31:0]     tlb_entryhi_i, tlb_pagemask_i, tlb_entrylo0_i, tlb_entrylo1_i;
  logic            cp0_index_we, cp0_tlbr_we;
  logic [31:0]     cp0_wdata_index, cp0_wdata_hi, cp0_wdata_pm, cp0_wdata_lo0, cp0_wdata_lo1;

  int checkCount = 0;
  int errorCount = 0;
  logic cmpEn = 1'b0;

  always #5 clk = ~clk;

  tlb_op_ctrl dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .ex_flush_i(ex_flush_i), .stall_o(stall_o), .refetch_o(refetch_o), .cp0_index_i(cp0_index_i),
    .cp0_wired_i(cp0_wired_i), .cp0_wired_we(cp0_wired_we), .tlb_typeM(tlb_typeM),
    .tlb_index_o(tlb_index_o), .tlb_random_o(tlb_random_o), .tlb_index_i(tlb_index_i),
    .tlb_entryhi_i(tlb_entryhi_i), .tlb_pagemask_i(tlb_pagemask_i),
    .tlb_entrylo0_i(tlb_entrylo0_i), .tlb_entrylo1_i(tlb_entrylo1_i),
    .cp0_index_we(cp0_index_we), .cp0_tlbr_we(cp0_tlbr_we), .cp0_wdata_index(cp0_wdata_index),
    .cp0_wdata_hi(cp0_wdata_hi), .cp0_wdata_pm(cp0_wdata_pm), .cp0_wdata_lo0(cp0_wdata_lo0),
    .cp0_wdata_lo1(cp0_wdata_lo1)
  );

  // Stand-in TLB: CP0 source registers, entry storage, probe by VPN2 and read by index.
  logic [31:0] cp0EntryHi = '0, cp0PageMask = '0, cp0EntryLo0 = '0, cp0EntryLo1 = '0;
  logic [31:0] tlbHi[TLBNUM], tlbPm[TLBNUM], tlbLo0[TLBNUM], tlbLo1[TLBNUM];
  logic        tlbValid[TLBNUM];
  logic [31:0] probeRes;
  logic [4:0]  writeIdx;

  initial begin
    for (int i = 0; i < TLBNUM; i++) begin
      tlbHi[i] = '0; tlbPm[i] = '0; tlbLo0[i] = '0; tlbLo1[i] = '0; tlbValid[i] = 1'b0;
    end
  end

  always_comb begin
    probeRes = 32'h8000_0000;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (tlbValid[i] && (tlbHi[i][31:13] == cp0EntryHi[31:13])) probeRes = 32'(i);
  end

  assign tlb_index_i    = probeRes;
  assign tlb_entryhi_i  = tlbHi[tlb_index_o[4:0]];
  assign tlb_pagemask_i = tlbPm[tlb_index_o[4:0]];
  assign tlb_entrylo0_i = tlbLo0[tlb_index_o[4:0]];
  assign tlb_entrylo1_i = tlbLo1[tlb_index_o[4:0]];

  always @(posedge clk) begin
    if (tlb_typeM == TLBWI || tlb_typeM == TLBWR) begin
      writeIdx = (tlb_typeM == TLBWI) ? tlb_index_o[4:0] : tlb_random_o[4:0];
      tlbHi[writeIdx]    <= cp0EntryHi;
      tlbPm[writeIdx]    <= cp0PageMask;
      tlbLo0[writeIdx]   <= cp0EntryLo0;
      tlbLo1[writeIdx]   <= cp0EntryLo1;
      tlbValid[writeIdx] <= 1'b1;
    end
  end

  // Model: phase 0 idle, 1 the cycle the op is on the TLB, 2 the cycle its result is delivered.
  int          mPhase = 0;
  logic [2:0]  mOp = NONE;
  logic [4:0]  mIdx = '0;
  int          mRand = TLBNUM - 1;
  logic [31:0] mWdIdx = '0, mWdHi = '0, mWdPm = '0, mWdLo0 = '0, mWdLo1 = '0;
  logic        expAccept;
  logic        frz;

  function automatic logic realOp(input logic [2:0] op);
    return op inside {TLBP, TLBR, TLBWI, TLBWR};
  endfunction

  always_comb expAccept = resetn && (mPhase == 0) && req_valid && realOp(req_op) && !ex_flush_i;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mPhase = 0; mOp = NONE; mIdx = '0; mRand = TLBNUM - 1;
      mWdIdx = '0; mWdHi = '0; mWdPm = '0; mWdLo0 = '0; mWdLo1 = '0;
    end else begin
      frz = expAccept || (mPhase == 1);
      if (mPhase == 1 && mOp == TLBP) mWdIdx = probeRes;
      if (mPhase == 1 && mOp == TLBR) begin
        mWdHi = tlbHi[mIdx]; mWdPm = tlbPm[mIdx]; mWdLo0 = tlbLo0[mIdx]; mWdLo1 = tlbLo1[mIdx];
      end
      if (cp0_wired_we) mRand = TLBNUM - 1;
      else if (!frz) mRand = (mRand <= int'(cp0_wired_i)) ? TLBNUM - 1 : mRand - 1;
      if (mPhase == 0 && expAccept) begin
        mPhase = 1; mOp = req_op; mIdx = cp0_index_i[4:0];
      end else if (mPhase == 1) mPhase = 2;
      else if (mPhase == 2) mPhase = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("req_ready", 32'(req_ready), 32'(expAccept));
      checkOutput("stall_o", 32'(stall_o), 32'(expAccept || mPhase != 0));
      checkOutput("tlb_typeM", 32'(tlb_typeM), (mPhase == 1) ? 32'(mOp) : 32'd0);
      checkOutput("tlb_index_o", tlb_index_o, 32'(mIdx));
      checkOutput("tlb_random_o", tlb_random_o, 32'(mRand));
      checkOutput("cp0_index_we", 32'(cp0_index_we), 32'(mPhase == 2 && mOp == TLBP));
      checkOutput("cp0_tlbr_we", 32'(cp0_tlbr_we), 32'(mPhase == 2 && mOp == TLBR));
      checkOutput("refetch_o", 32'(refetch_o), 32'(mPhase == 2 && (mOp == TLBWI || mOp == TLBWR)));
      checkOutput("wdata_index", cp0_wdata_index, mWdIdx);
      checkOutput("wdata_hi", cp0_wdata_hi, mWdHi);
      checkOutput("wdata_pm", cp0_wdata_pm, mWdPm);
      checkOutput("wdata_lo0", cp0_wdata_lo0, mWdLo0);
      checkOutput("wdata_lo1", cp0_wdata_lo1, mWdLo1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [31:0] idx, input logic flush);
    req_valid = valid; req_op = op; cp0_index_i = idx; ex_flush_i = flush;
    #1;
  endtask

  // Accept, issue, then return inside the capture/refetch cycle.
  task automatic runOp(input logic [2:0] op, input logic [31:0] idx);
    tick(); applyStimulus(1'b1, op, idx, 1'b0);
    tick(); applyStimulus(1'b0, NONE, 32'd0, 1'b0);
    tick(); #1;
  endtask

  initial begin
    #1 resetn = 1'b0;
    #1 cmpEn = 1'b1;
    repeat (3) tick();
    checkOutput("rst_random", tlb_random_o, 32'd31);
    checkOutput("rst_stall", 32'(stall_o), 32'd0);
    checkOutput("rst_typeM", 32'(tlb_typeM), 32'd0);
    checkOutput("rst_wdata_index", cp0_wdata_index, 32'd0);
    resetn = 1'b1;
    #1 checkOutput("rand_31", tlb_random_o, 32'd31);
    tick(); checkOutput("rand_30", tlb_random_o, 32'd30);
    tick(); checkOutput("rand_29", tlb_random_o, 32'd29);
    repeat (29) tick(); checkOutput("rand_0", tlb_random_o, 32'd0);
    tick(); checkOutput("rand_wrap", tlb_random_o, 32'd31);

    cp0_wired_i = 5'd8;
    repeat (22) tick(); checkOutput("wired_9", tlb_random_o, 32'd9);
    tick(); checkOutput("wired_8", tlb_random_o, 32'd8);
    tick(); checkOutput("wired_wrap", tlb_random_o, 32'd31);
    repeat (11) tick(); checkOutput("wired_we_20", tlb_random_o, 32'd20);
    cp0_wired_we = 1'b1;
    tick(); cp0_wired_we = 1'b0; #1;
    checkOutput("wired_we_31", tlb_random_o, 32'd31);
    cp0_wired_i = 5'd0;

    cp0EntryHi = 32'h0000_4000; cp0PageMask = '0;
    cp0EntryLo0 = 32'h0001_2345; cp0EntryLo1 = 32'h0006_7891;
    tick(); applyStimulus(1'b1, TLBWI, 32'hFFFF_FFEC, 1'b0);
    checkOutput("wi_ready", 32'(req_ready), 32'd1);
    checkOutput("wi_stall1", 32'(stall_o), 32'd1);
    tick(); applyStimulus(1'b0, NONE, 32'd0, 1'b0);
    checkOutput("wi_typeM", 32'(tlb_typeM), 32'(TLBWI));
    checkOutput("wi_index", tlb_index_o, 32'd12);
    checkOutput("wi_stall2", 32'(stall_o), 32'd1);
    tick(); #1;
    checkOutput("wi_refetch", 32'(refetch_o), 32'd1);
    checkOutput("wi_typeM_off", 32'(tlb_typeM), 32'd0);
    checkOutput("wi_stall3", 32'(stall_o), 32'd1);
    tick(); #1;
    checkOutput("wi_stall_end", 32'(stall_o), 32'd0);

    runOp(TLBP, 32'd0);
    checkOutput("tlbp_hit_we", 32'(cp0_index_we), 32'd1);
    checkOutput("tlbp_hit_idx", cp0_wdata_index, 32'd12);
    cp0EntryHi = 32'h0ABC_0000;
    runOp(TLBP, 32'd0);
    checkOutput("tlbp_miss_we", 32'(cp0_index_we), 32'd1);
    checkOutput("tlbp_miss_idx", cp0_wdata_index, 32'h8000_0000);

    cp0EntryHi = 32'h0000_8000; cp0EntryLo0 = 32'hAAAA_0001; cp0EntryLo1 = 32'h5555_0002;
    for (int k = 0; k < 64 && mRand != 18; k++) tick();
    if (mRand != 18) checkOutput("wait_rand18", 32'(mRand), 32'd18);
    tick(); applyStimulus(1'b1, TLBWR, 32'd0, 1'b0);
    checkOutput("wr_rand_accept", tlb_random_o, 32'd17);
    tick(); applyStimulus(1'b0, NONE, 32'd0, 1'b0);
    checkOutput("wr_typeM", 32'(tlb_typeM), 32'(TLBWR));
    checkOutput("wr_rand_issue", tlb_random_o, 32'd17);
    tick(); #1;
    checkOutput("wr_refetch", 32'(refetch_o), 32'd1);
    runOp(TLBR, 32'd17);
    checkOutput("tlbr_we", 32'(cp0_tlbr_we), 32'd1);
    checkOutput("tlbr_hi", cp0_wdata_hi, 32'h0000_8000);
    checkOutput("tlbr_lo0", cp0_wdata_lo0, 32'hAAAA_0001);
    checkOutput("tlbr_lo1", cp0_wdata_lo1, 32'h5555_0002);

    tick(); applyStimulus(1'b1, TLBP, 32'd0, 1'b1);
    checkOutput("flush_ready", 32'(req_ready), 32'd0);
    checkOutput("flush_stall", 32'(stall_o), 32'd0);
    tick(); applyStimulus(1'b0, NONE, 32'd0, 1'b0);
    checkOutput("flush_typeM", 32'(tlb_typeM), 32'd0);
    tick(); applyStimulus(1'b1, 3'd7, 32'd0, 1'b0);
    checkOutput("undef_ready", 32'(req_ready), 32'd0);
    tick(); applyStimulus(1'b0, NONE, 32'd0, 1'b0);

    tick(); applyStimulus(1'b1, TLBWI, 32'd5, 1'b0);
    tick(); applyStimulus(1'b0, NONE, 32'd0, 1'b0);
    checkOutput("rstop_typeM_pre", 32'(tlb_typeM), 32'(TLBWI));
    resetn = 1'b0;
    #1;
    checkOutput("rstop_typeM", 32'(tlb_typeM), 32'd0);
    checkOutput("rstop_stall", 32'(stall_o), 32'd0);
    tick(); checkOutput("rstop_refetch", 32'(refetch_o), 32'd0);
    resetn = 1'b1;
    tick(); checkOutput("rstop_refetch2", 32'(refetch_o), 32'd0);
    runOp(TLBR, 32'd5);
    checkOutput("rstop_nowrite_hi", cp0_wdata_hi, 32'd0);
    checkOutput("rstop_nowrite_lo0", cp0_wdata_lo0, 32'd0);

    tick(); tick();
    cmpEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
